// File: rtl/display_controller_if.sv
// Request/grant read port from the display controller into data memory.
// The controller drives the master side; the memory arbiter drives the slave side.
interface display_controller_if #(
  parameter int DM_ADDR_WIDTH = 5
);
  logic                     ram_req;
  logic [DM_ADDR_WIDTH-1:0] ram_addr;
  logic                     ram_gnt;
  logic [31:0]              ram_rdata;

  modport master (output ram_req, ram_addr, input ram_gnt, ram_rdata);
  modport slave  (input ram_req, ram_addr, output ram_gnt, ram_rdata);
endinterface

// File: rtl/display_controller.sv
// Eight-digit hex scanner for the board display, with source selection and a
// request/grant fetch port for showing data-memory words.
module display_controller #(
  parameter int SCAN_DIV      = 100000,
  parameter int REFRESH       = 1000000,
  parameter int DM_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     switch_stat,
  input  logic                     switch_ram,
  input  logic                     switch_correctprediction,
  input  logic                     switch_misprediction,
  input  logic [DM_ADDR_WIDTH-1:0] switch_addr,
  input  logic [31:0]              led_data,
  input  logic [31:0]              stat_count,
  input  logic [31:0]              stat_correctprediction,
  input  logic [31:0]              stat_misprediction,
  display_controller_if.master     ram_bus,
  output logic [7:0]               anodes,
  output logic [7:0]               cnodes
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int REF_W = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} ram_state_t;

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 8'hC0;  4'h1: hex_seg = 8'hF9;
      4'h2: hex_seg = 8'hA4;  4'h3: hex_seg = 8'hB0;
      4'h4: hex_seg = 8'h99;  4'h5: hex_seg = 8'h92;
      4'h6: hex_seg = 8'h82;  4'h7: hex_seg = 8'hF8;
      4'h8: hex_seg = 8'h80;  4'h9: hex_seg = 8'h90;
      4'hA: hex_seg = 8'h88;  4'hB: hex_seg = 8'h83;
      4'hC: hex_seg = 8'hC6;  4'hD: hex_seg = 8'hA1;
      4'hE: hex_seg = 8'h86;  default: hex_seg = 8'h8E;
    endcase
  endfunction

  logic [DIV_W-1:0]         div_q, div_d;
  logic [2:0]               digit_q, digit_d;
  logic [31:0]              disp_q, disp_d, src_sel;
  logic [7:0]               anodes_q, anodes_d, cnodes_q, cnodes_d;
  logic [3:0]               nib [8];
  logic                     digit_tick;

  ram_state_t               state_q;
  logic                     ram_req_q;
  logic [DM_ADDR_WIDTH-1:0] ram_addr_q;
  logic [31:0]              ram_buf_q;
  logic [REF_W-1:0]         refresh_q;

  always_comb begin
    src_sel = led_data;
    if (switch_ram)                    src_sel = ram_buf_q;
    else if (switch_misprediction)     src_sel = stat_misprediction;
    else if (switch_correctprediction) src_sel = stat_correctprediction;
    else if (switch_stat)              src_sel = stat_count;
  end

  assign digit_tick = (div_q == DIV_LAST);

  // The segment code is built from disp_d so digit 0 of a new frame already
  // shows the word loaded on that same wrap edge.
  always_comb begin
    div_d    = digit_tick ? '0 : div_q + 1'b1;
    digit_d  = digit_tick ? digit_q + 3'd1 : digit_q;
    disp_d   = (digit_tick && digit_q == 3'd7) ? src_sel : disp_q;
    anodes_d = digit_tick ? ~(8'b1 << digit_d) : anodes_q;
    cnodes_d = digit_tick ? hex_seg(nib[digit_d]) : cnodes_q;
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_nib
    assign nib[gi] = disp_d[4*gi +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      digit_q  <= 3'd0;
      disp_q   <= 32'd0;
      anodes_q <= 8'hFE;
      cnodes_q <= 8'hC0;
    end else begin
      div_q    <= div_d;
      digit_q  <= digit_d;
      disp_q   <= disp_d;
      anodes_q <= anodes_d;
      cnodes_q <= cnodes_d;
    end
  end

  // A raised request is never withdrawn: switch changes are only acted on in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ram_req_q  <= 1'b0;
      ram_addr_q <= '0;
      ram_buf_q  <= 32'd0;
      refresh_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ram_req_q <= 1'b0;
          if (switch_ram) begin
            ram_addr_q <= switch_addr;
            ram_req_q  <= 1'b1;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          if (ram_bus.ram_gnt) begin
            ram_req_q <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          ram_buf_q <= ram_bus.ram_rdata;
          refresh_q <= '0;
          state_q   <= S_HOLD;
        end
        S_HOLD: begin
          refresh_q <= refresh_q + 1'b1;
          if (!switch_ram) begin
            state_q <= S_IDLE;
          end else if (switch_addr != ram_addr_q) begin
            ram_addr_q <= switch_addr;
            ram_req_q  <= 1'b1;
            state_q    <= S_REQ;
          end else if (refresh_q == REF_LAST) begin
            ram_req_q <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        default: begin
          ram_req_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign ram_bus.ram_req  = ram_req_q;
  assign ram_bus.ram_addr = ram_addr_q;
  assign anodes           = anodes_q;
  assign cnodes           = cnodes_q;

endmodule
